irq_retryer_mc: RTL and testbench

//  Multi-channel interrupt retry engine for the AXI memory-writer interrupt path.
//  - Counts un-acknowledged interrupt events per channel.
//  - Re-signals any channel whose events stay pending longer than a runtime-programmable period.
//  - Serialises all retry requests through a round-robin arbiter onto one retry strobe plus channel index.
//  - Sits between the writer's per-channel event sources and the interrupt controller / driver ack path.

---
 rtl/irq_retryer_mc.sv | 178 +++++++++++++++++
 tb/tb_irq_retryer_mc.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_retryer_mc.sv
// irq_retryer_mc: counts un-acknowledged interrupt events per channel and
// re-signals any channel that stays pending longer than RETRY_PERIOD cycles.
// A round-robin arbiter serialises the retries onto one strobe plus index.
// Optional feature macro: IRQ_RETRYER_OVERFLOW_EN adds sticky saturation flags.
`timescale 1ns/1ps
module irq_retryer_mc #(
   parameter int N_CH   = 4,
   parameter int CNT_W  = 32,
   parameter int PEND_W = 6,
   localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic              CLK,
   input  logic              RESETN,
   input  logic [CNT_W-1:0]  RETRY_PERIOD,
   input  logic [N_CH-1:0]   EVENT_IN,
   input  logic [N_CH-1:0]   EVENT_ACK,
   output logic [N_CH-1:0]   PENDING,
   output logic              RETRY_VALID,
   output logic [CH_W-1:0]   RETRY_CH,
   output logic [N_CH-1:0]   OVERFLOW,
   input  logic [N_CH-1:0]   OVF_CLR
);

   localparam logic [PEND_W-1:0] PEND_MAX = '1;
   localparam logic [CNT_W-1:0]  ONE      = CNT_W'(1);

   logic [N_CH-1:0]   ev_in_q, ev_in_d, ack_in_q, ack_in_d;
   logic              armed_q, armed_d;
   logic [N_CH-1:0]   ev_p_q, ev_p_d, ack_p_q, ack_p_d;
   logic [PEND_W-1:0] cnt_q [N_CH];
   logic [PEND_W-1:0] cnt_d [N_CH];
   logic [N_CH-1:0]   pending_q, pending_d;
   logic [CNT_W-1:0]  tmr_q [N_CH];
   logic [CNT_W-1:0]  tmr_d [N_CH];
   logic [N_CH-1:0]   req_q, req_d, req_eff;
   logic [CH_W-1:0]   ptr_q, ptr_d;
   logic              retry_valid_q, retry_valid_d;
   logic [CH_W-1:0]   retry_ch_q, retry_ch_d;
   logic              grant_vld;
   logic [CH_W-1:0]   grant_idx, arb_idx;
   logic              period_ok;
   logic [CNT_W-1:0]  period_m1;

   // (base + off) mod N_CH without a generic divider
   function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base,
                                               input int unsigned off);
      logic [CH_W:0] sum;
      sum = {1'b0, base} + (CH_W+1)'(off);
      if (sum >= (CH_W+1)'(N_CH)) sum = sum - (CH_W+1)'(N_CH);
      return sum[CH_W-1:0];
   endfunction

   // Rising-edge detection; the first sampled cycle after reset is never an edge
   always_comb begin
      ev_in_d  = EVENT_IN;
      ack_in_d = EVENT_ACK;
      armed_d  = 1'b1;
      ev_p_d   = armed_q ? (EVENT_IN  & ~ev_in_q)  : '0;
      ack_p_d  = armed_q ? (EVENT_ACK & ~ack_in_q) : '0;
   end

   // Saturating pending counters and registered non-zero flag
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         cnt_d[i]     = cnt_q[i];
         pending_d[i] = (cnt_q[i] != '0);
         if (ev_p_q[i] && !ack_p_q[i] && cnt_q[i] != PEND_MAX)
            cnt_d[i] = cnt_q[i] + PEND_W'(1);
         else if (ack_p_q[i] && !ev_p_q[i] && cnt_q[i] != '0)
            cnt_d[i] = cnt_q[i] - PEND_W'(1);
      end
   end

   // Round-robin grant: first live request at or after the pointer
   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      req_eff   = req_q & pending_q;
      grant_vld = 1'b0;
      grant_idx = '0;
      arb_idx   = '0;
      for (int k = 0; k < N_CH; k++) begin
         arb_idx = wrap_add(ptr_q, int'(k));
         if (!grant_vld && req_eff[arb_idx]) begin
            grant_vld = 1'b1;
            grant_idx = arb_idx;
         end
      end
      ptr_d         = grant_vld ? wrap_add(grant_idx, 1) : ptr_q;
      retry_valid_d = grant_vld;
      retry_ch_d    = grant_idx;
   end

   // Retry timers and sticky request vector
   always_comb begin
      period_ok = (RETRY_PERIOD > ONE);
      period_m1 = RETRY_PERIOD - ONE;
      req_d     = req_q;
      if (grant_vld) req_d[grant_idx] = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         tmr_d[i] = '0;
         if (pending_q[i] && period_ok) begin
            if (ev_p_q[i]) begin
               tmr_d[i] = '0;
            end else if (tmr_q[i] >= period_m1) begin
               tmr_d[i] = '0;
               req_d[i] = 1'b1;
            end else begin
               tmr_d[i] = tmr_q[i] + ONE;
            end
         end
         if (!pending_q[i]) req_d[i] = 1'b0;
      end
   end

   // State registers
   always_ff @(posedge CLK or negedge RESETN) begin
      // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
      if (!RESETN) begin
         ev_in_q       <= '0;
         ack_in_q      <= '0;
         armed_q       <= 1'b0;
         ev_p_q        <= '0;
         ack_p_q       <= '0;
         pending_q     <= '0;
         req_q         <= '0;
         ptr_q         <= '0;
         retry_valid_q <= 1'b0;
         retry_ch_q    <= '0;
         // NOTE: these arrays are flop banks, not RAM, so they take the async reset like any other state.
         for (int i = 0; i < N_CH; i++) begin
            cnt_q[i] <= '0;
            tmr_q[i] <= '0;
         end
      end else begin
         ev_in_q       <= ev_in_d;
         ack_in_q      <= ack_in_d;
         armed_q       <= armed_d;
         ev_p_q        <= ev_p_d;
         ack_p_q       <= ack_p_d;
         pending_q     <= pending_d;
         req_q         <= req_d;
         ptr_q         <= ptr_d;
         retry_valid_q <= retry_valid_d;
         retry_ch_q    <= retry_ch_d;
         cnt_q         <= cnt_d;
         tmr_q         <= tmr_d;
      end
   end

`ifdef IRQ_RETRYER_OVERFLOW_EN
   logic [N_CH-1:0] ovf_q, ovf_d;

   // Sticky overflow: set on an increment attempt at max, clear has priority
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         ovf_d[i] = ovf_q[i] | (ev_p_q[i] & ~ack_p_q[i] & (cnt_q[i] == PEND_MAX));
         if (OVF_CLR[i]) ovf_d[i] = 1'b0;
      end
   end

   // Overflow flag register
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) ovf_q <= '0;
      else         ovf_q <= ovf_d;
   end

   assign OVERFLOW = ovf_q;
`else
   logic unused_ovf_clr;
   assign unused_ovf_clr = ^OVF_CLR;
   assign OVERFLOW       = '0;
`endif

   assign PENDING     = pending_q;
   assign RETRY_VALID = retry_valid_q;
   assign RETRY_CH    = retry_ch_q;

endmodule

// File: tb/tb_irq_retryer_mc.sv
// Scoreboard bench for irq_retryer_mc: a behavioural model pushes expected
// retry channels into a queue; a negedge monitor pops and compares them and
// also compares PENDING/OVERFLOW every cycle. Directed scenarios then random.
`timescale 1ns/1ps
module tb_irq_retryer_mc;
   localparam int N_CH   = 4;
   localparam int CNT_W  = 32;
   localparam int PEND_W = 3;
   localparam int CH_W   = 2;
   localparam int PMAX   = (1 << PEND_W) - 1;

   logic              CLK = 1'b0;
   logic              RESETN = 1'b0;
   logic [CNT_W-1:0]  RETRY_PERIOD = '0;
   logic [N_CH-1:0]   EVENT_IN = '0;
   logic [N_CH-1:0]   EVENT_ACK = '0;
   logic [N_CH-1:0]   PENDING;
   logic              RETRY_VALID;
   logic [CH_W-1:0]   RETRY_CH;
   logic [N_CH-1:0]   OVERFLOW;
   logic [N_CH-1:0]   OVF_CLR = '0;

   irq_retryer_mc #(.N_CH(N_CH), .CNT_W(CNT_W), .PEND_W(PEND_W)) dut (
      .CLK(CLK), .RESETN(RESETN), .RETRY_PERIOD(RETRY_PERIOD),
      .EVENT_IN(EVENT_IN), .EVENT_ACK(EVENT_ACK), .PENDING(PENDING),
      .RETRY_VALID(RETRY_VALID), .RETRY_CH(RETRY_CH), .OVERFLOW(OVERFLOW),
      .OVF_CLR(OVF_CLR));

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;
   int n_valid  = 0;
   int exp_q[$];
   int seen_ch[$];

   // Behavioural model state: plain integers per channel
   bit     m_armed;
   bit     m_prev_ev[N_CH], m_prev_ack[N_CH], m_evp[N_CH], m_ackp[N_CH];
   bit     m_pend[N_CH], m_req[N_CH], m_ovf[N_CH];
   int     m_cnt[N_CH];
   longint m_tmr[N_CH];
   int     m_ptr;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_armed = 1'b0;
      m_ptr   = 0;
      for (int i = 0; i < N_CH; i++) begin
         m_prev_ev[i] = 0; m_prev_ack[i] = 0; m_evp[i] = 0; m_ackp[i] = 0;
         m_pend[i] = 0; m_req[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0; m_tmr[i] = 0;
      end
      exp_q.delete();
   endtask

   // One clock of the reference behaviour, computed from current model state
   task automatic model_step();
      longint p;
      int     g;
      p = longint'(RETRY_PERIOD);
      g = -1;
      for (int k = 0; k < N_CH; k++) begin
         int c;
         c = (m_ptr + k) % N_CH;
         if (g < 0 && m_req[c] && m_pend[c]) g = c;
      end
      if (g >= 0) begin
         exp_q.push_back(g);
         m_req[g] = 0;
         m_ptr    = (g + 1) % N_CH;
      end
      for (int i = 0; i < N_CH; i++) begin
         if (m_pend[i] && p >= 2) begin
            if (m_evp[i]) m_tmr[i] = 0;
            else if (m_tmr[i] >= p - 1) begin
               m_tmr[i] = 0;
               m_req[i] = 1;
            end else m_tmr[i]++;
         end else m_tmr[i] = 0;
         if (!m_pend[i]) m_req[i] = 0;
         m_pend[i] = (m_cnt[i] != 0);
         if (m_evp[i] && !m_ackp[i]) begin
            if (m_cnt[i] == PMAX) begin
`ifdef IRQ_RETRYER_OVERFLOW_EN
               m_ovf[i] = 1;
`endif
            end else m_cnt[i]++;
         end else if (m_ackp[i] && !m_evp[i] && m_cnt[i] > 0) m_cnt[i]--;
`ifdef IRQ_RETRYER_OVERFLOW_EN
         if (OVF_CLR[i]) m_ovf[i] = 0;
`endif
         m_evp[i]      = m_armed && EVENT_IN[i]  && !m_prev_ev[i];
         m_ackp[i]     = m_armed && EVENT_ACK[i] && !m_prev_ack[i];
         m_prev_ev[i]  = EVENT_IN[i];
         m_prev_ack[i] = EVENT_ACK[i];
      end
      m_armed = 1'b1;
   endtask

   function automatic logic [N_CH-1:0] m_pend_vec();
      logic [N_CH-1:0] v;
      for (int i = 0; i < N_CH; i++) v[i] = m_pend[i];
      return v;
   endfunction

   function automatic logic [N_CH-1:0] m_ovf_vec();
      logic [N_CH-1:0] v;
      for (int i = 0; i < N_CH; i++) v[i] = m_ovf[i];
      return v;
   endfunction

   // Model process
   initial begin
      model_reset();
      forever begin
         @(posedge CLK or negedge RESETN);
         if (!RESETN) model_reset();
         else         model_step();
      end
   end

   // Monitor: compare DUT outputs against the model away from the active edge
   initial begin
      forever begin
         @(negedge CLK);
         if (RESETN) begin
            check("pending", 64'(PENDING), 64'(m_pend_vec()));
            check("overflow", 64'(OVERFLOW), 64'(m_ovf_vec()));
            if (RETRY_VALID) begin
               n_valid++;
               seen_ch.push_back(int'(RETRY_CH));
            end
            if (exp_q.size() > 0) begin
               int e;
               e = exp_q.pop_front();
               check("retry_valid", 64'(RETRY_VALID), 64'(1));
               check("retry_ch", 64'(RETRY_CH), 64'(e));
            end else begin
               check("retry_valid_idle", 64'(RETRY_VALID), 64'(0));
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit exceeded");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic pulse(input logic [N_CH-1:0] ev, input logic [N_CH-1:0] ack);
      @(negedge CLK);
      EVENT_IN  = EVENT_IN | ev;
      EVENT_ACK = EVENT_ACK | ack;
      @(negedge CLK);
      EVENT_IN  = EVENT_IN & ~ev;
      EVENT_ACK = EVENT_ACK & ~ack;
      @(negedge CLK);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_pending"}, 64'(PENDING), 64'(0));
      check({tag, "_valid"}, 64'(RETRY_VALID), 64'(0));
      check({tag, "_ch"}, 64'(RETRY_CH), 64'(0));
      check({tag, "_overflow"}, 64'(OVERFLOW), 64'(0));
   endtask

   task automatic do_reset();
      @(negedge CLK);
      #2;
      RESETN = 1'b0;
      #1;
      check_outputs_zero("rst");
      EVENT_IN = '0; EVENT_ACK = '0; OVF_CLR = '0;
      @(negedge CLK);
      #2;
      RESETN = 1'b1;
   endtask

   initial begin
      int n0;
      int unsigned periods[8] = '{0, 1, 2, 3, 4, 7, 15, 40};

      // Reset state, with an input already high at release (not an edge)
      EVENT_IN = 4'b0001;
      #13;
      check_outputs_zero("init");
      @(negedge CLK);
      #2;
      RESETN = 1'b1;
      tick(5);
      check("high_at_release", 64'(PENDING), 64'(0));
      EVENT_IN = '0;
      tick(3);

      // T1: single event on ch2, period 100
      do_reset();
      RETRY_PERIOD = 100;
      n0 = n_valid;
      @(negedge CLK); EVENT_IN[2] = 1'b1;
      @(negedge CLK); check("t1_pend_t1", 64'(PENDING), 64'(0)); EVENT_IN[2] = 1'b0;
      @(negedge CLK); check("t1_pend_t2", 64'(PENDING), 64'(0));
      @(negedge CLK); check("t1_pend_t3", 64'(PENDING), 64'(4'b0100));
      tick(320);
      check("t1_strobes", 64'(n_valid - n0), 64'(3));

      // T2: ack before the next expiry
      n0 = n_valid;
      pulse(4'b0000, 4'b0100);
      tick(150);
      check("t2_pending", 64'(PENDING), 64'(0));
      check("t2_strobes", 64'(n_valid - n0), 64'(0));

      // T3: three channels in the same cycle, period 50
      do_reset();
      RETRY_PERIOD = 50;
      seen_ch.delete();
      pulse(4'b1011, 4'b0000);
      tick(130);
      check("t3_count", 64'(seen_ch.size()), 64'(6));
      for (int k = 0; k < 6; k++) begin
         int want;
         want = (k % 3 == 2) ? 3 : (k % 3);
         if (k < seen_ch.size()) check("t3_order", 64'(seen_ch[k]), 64'(want));
      end

      // T4: event and ack together at cnt=3 hold the count
      do_reset();
      RETRY_PERIOD = 1000;
      repeat (3) pulse(4'b0010, 4'b0000);
      pulse(4'b0010, 4'b0010);
      repeat (2) pulse(4'b0000, 4'b0010);
      tick(3);
      check("t4_after_2_acks", 64'(PENDING), 64'(4'b0010));
      pulse(4'b0000, 4'b0010);
      tick(3);
      check("t4_after_3_acks", 64'(PENDING), 64'(0));

      // T5: saturation on ch0
      do_reset();
      RETRY_PERIOD = 0;
      repeat (9) pulse(4'b0001, 4'b0000);
      tick(3);
`ifdef IRQ_RETRYER_OVERFLOW_EN
      check("t5_overflow_set", 64'(OVERFLOW), 64'(4'b0001));
`else
      check("t5_overflow_off", 64'(OVERFLOW), 64'(0));
`endif
      @(negedge CLK); OVF_CLR = 4'b0001;
      @(negedge CLK); OVF_CLR = '0;
      tick(2);
      check("t5_overflow_clr", 64'(OVERFLOW), 64'(0));
      repeat (6) pulse(4'b0000, 4'b0001);
      tick(3);
      check("t5_after_6_acks", 64'(PENDING), 64'(4'b0001));
      pulse(4'b0000, 4'b0001);
      tick(3);
      check("t5_after_7_acks", 64'(PENDING), 64'(0));

      // T6: shrink the period mid-count, async reset, period 0
      do_reset();
      RETRY_PERIOD = 1000;
      pulse(4'b1000, 4'b0000);
      tick(497);
      n0 = n_valid;
      RETRY_PERIOD = 10;
      tick(4);
      check("t6_shrink_strobe", 64'(n_valid - n0), 64'(1));
      tick(3);
      @(posedge CLK);
      #2;
      RESETN = 1'b0;
      #1;
      check_outputs_zero("t6_async");
      @(negedge CLK);
      #2;
      RESETN = 1'b1;
      RETRY_PERIOD = 0;
      n0 = n_valid;
      pulse(4'b1111, 4'b0000);
      tick(200);
      check("t6_period0_pending", 64'(PENDING), 64'(4'b1111));
      check("t6_period0_strobes", 64'(n_valid - n0), 64'(0));

      // Random traffic against the model
      do_reset();
      RETRY_PERIOD = 7;
      for (int c = 0; c < 3000; c++) begin
         @(negedge CLK);
         for (int i = 0; i < N_CH; i++) begin
            if ($urandom_range(7) == 0) EVENT_IN[i]  = ~EVENT_IN[i];
            if ($urandom_range(9) == 0) EVENT_ACK[i] = ~EVENT_ACK[i];
            OVF_CLR[i] = ($urandom_range(15) == 0);
         end
         if ($urandom_range(199) == 0) RETRY_PERIOD = periods[$urandom_range(7)];
      end
      EVENT_IN = '0; EVENT_ACK = '0; OVF_CLR = '0;
      tick(5);
      check("queue_drained", 64'(exp_q.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
